// File: rtl/a_rom_stream_ctrl.sv
// Streams a packed two-element-per-word A-matrix ROM over valid/ready, replaying it
// NUM_PASSES times. The ROM address is driven one word ahead to hide its registered read latency.
module a_rom_stream_ctrl #(
  parameter int NUM_WORDS  = 16,
  parameter int ADDR_W     = 4,
  parameter int ELEM_W     = 7,
  parameter int NUM_PASSES = 8,
  parameter int PASS_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [2*ELEM_W-1:0] rom_data,
  output logic [ELEM_W-1:0]   elem_even,
  output logic [ELEM_W-1:0]   elem_odd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   word_idx,
  output logic [PASS_W-1:0]   pass_idx,
  output logic                last_word,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;

  logic                fire;
  logic                final_word;
  logic [ADDR_W-1:0]   next_addr;

  assign fire       = (state_q == STREAM) && out_ready;
  assign final_word = (word_idx_q == LAST_WORD) && (pass_idx_q == LAST_PASS);
  // Address width is exactly log2(NUM_WORDS), so the increment wraps 15->0 by itself.
  assign next_addr  = final_word ? '0 : addr_q + ADDR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_idx_q <= '0;
      pass_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_idx_q <= word_idx_d;
      pass_idx_q <= pass_idx_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = STREAM;
      STREAM:  if (fire && final_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    word_idx_d = word_idx_q;
    pass_idx_d = pass_idx_q;
    if (state_q == IDLE && start) begin
      addr_d     = '0;
      word_idx_d = '0;
      pass_idx_d = '0;
    end else if (fire) begin
      addr_d = next_addr;
      if (!final_word) begin
        if (word_idx_q == LAST_WORD) begin
          word_idx_d = '0;
          pass_idx_d = pass_idx_q + PASS_W'(1);
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    out_valid = (state_q == STREAM);
    busy      = (state_q == FETCH) || (state_q == STREAM);
    done      = (state_q == DONE);
    // Lookahead: on a handshake the ROM samples the next word on this same edge.
    rom_addr  = '0;
    if (state_q == STREAM) rom_addr = fire ? next_addr : addr_q;
    else if (state_q == DONE) rom_addr = addr_q;
    elem_even = out_valid ? rom_data[2*ELEM_W-1:ELEM_W] : '0;
    elem_odd  = out_valid ? rom_data[ELEM_W-1:0] : '0;
    word_idx  = word_idx_q;
    pass_idx  = pass_idx_q;
    last_word = out_valid && (word_idx_q == LAST_WORD);
  end

endmodule

// File: doc/a_rom_stream_ctrl.md
Name: a_rom_stream_ctrl

Overview:
Sequencer that streams the packed A-matrix ROM (16 words × 14 bits, each word holding two 7-bit elements) to the downstream MAC datapath over a valid/ready interface. It replays the full ROM NUM_PASSES times, once per B column. It drives the ROM address with one-word lookahead, so it sustains one word per cycle despite the ROM's one-cycle registered read latency. It reports progress through index outputs and signals completion with busy/done.

Parameters:
NUM_WORDS, 16, ROM words per pass; equals 2^ADDR_W.
ADDR_W, 4, ROM address width.
ELEM_W, 7, element width; ROM word width is 2*ELEM_W.
NUM_PASSES, 8, number of full ROM replays per start.
PASS_W, 3, width of pass_idx; equals clog2(NUM_PASSES).

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
rom_addr  out  ADDR_W  address to A ROM
rom_data  in  2*ELEM_W  ROM registered output; reflects the address sampled one edge earlier
elem_even  out  ELEM_W  rom_data[2*ELEM_W-1:ELEM_W] (entry 2*addr) when out_valid, else 0
elem_odd  out  ELEM_W  rom_data[ELEM_W-1:0] (entry 2*addr+1) when out_valid, else 0
out_valid  out  1  elem_even/elem_odd valid
out_ready  in  1  downstream accepts
word_idx  out  ADDR_W  index of word currently presented
pass_idx  out  PASS_W  current pass
last_word  out  1  out_valid && word_idx==NUM_WORDS-1
busy  out  1  high in FETCH and STREAM
done  out  1  one-cycle pulse after final handshake

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE.
  - addr_q, word_idx and pass_idx go to 0.
  - out_valid, busy, done and last_word go to 0.
  - Reset mid-run aborts immediately with no done pulse. The next start begins at word 0, pass 0.
- States: IDLE, FETCH, STREAM, DONE.
  - IDLE: rom_addr=0. When start=1, go to FETCH with word_idx=0 and pass_idx=0.
  - FETCH: one priming cycle; rom_addr=0, out_valid=0, busy=1. Always go to STREAM.
  - STREAM: out_valid=1, busy=1. The elem_* outputs come from rom_data.
  - DONE: done=1, busy=0, out_valid=0. Always go to IDLE. start is ignored here.
- Handshake in STREAM: fire = out_valid && out_ready.
  - Without fire, all outputs hold. rom_addr=addr_q, so rom_data stays stable.
- Lookahead: rom_addr = fire ? next_addr : addr_q. This is a combinational path from out_ready to rom_addr. It lets the ROM sample the next word on the same edge as the handshake, so the next cycle presents the new word with no bubble.
- On fire, unless this is the final word:
  - If word_idx < NUM_WORDS-1, word_idx increments.
  - Otherwise word_idx wraps to 0 and pass_idx increments. next_addr wraps 15→0 seamlessly.
- Final word: fire at word_idx=NUM_WORDS-1 and pass_idx=NUM_PASSES-1 goes to DONE.
  - next_addr is 0 on that fire.
  - done asserts in the following cycle.
- Latency:
  - start sampled at edge k → FETCH in cycle k+1 → first out_valid in cycle k+2 with word 0.
  - With out_ready held at 1: NUM_WORDS*NUM_PASSES consecutive valid cycles, then done in the next cycle.
  - Total from start edge to done cycle: 2 + 128 cycles at defaults.
- start while busy or in DONE: ignored, with no effect on the run.
- The ROM's own reset zeroes rom_data. The controller never asserts out_valid before FETCH has primed the address, so the ROM's reset value is never presented.

Test Plan:
- Reset behaviour: rst=0 for 2 cycles, then start=1 for one cycle with out_ready=1 → out_valid first high 2 cycles after the start edge. Word 0 shows elem_even=mem[0] and elem_odd=mem[1]. Data is a fresh sequence, no stale output.
- Full-throughput run: out_ready=1 for the whole run → 128 back-to-back valid words. Addresses go 0..15 repeated 8 times. pass_idx steps 0..7 on each wrap. last_word is high 8 times. done pulses exactly once, 130 cycles after the start edge.
- Backpressure: drop out_ready for 3 cycles while word 5 is presented → word_idx=5 and elem_* are held unchanged for 3 cycles. rom_addr stays 5 during the stall. Word 6 appears in the cycle after ready returns, with no bubble and no skipped or duplicated word.
- Pass wrap under stall: stall at word 15 of pass 0, then release → the next word is word 0 with pass_idx=1. rom_addr is 0 on the release cycle.
- Ignored start: pulse start at word 40 and during the DONE cycle → the sequence is unaffected and done pulses once.
- Reset mid-run: rst=0 at word 70 → out_valid, busy and done drop to 0 with no done pulse. A new start replays from word 0, pass 0.
